i2c_config_arbiter: RTL and testbench

Shares the single I2C master between two configuration requesters: port 0 is the HDMI transmitter config queue and port 1 is the audio codec config queue. Each requester hands over one 3-byte write (7-bit device address, register byte, data byte) with a start pulse. The arbiter queues requests and grants the master round-robin. It drives one start pulse per transaction and reports per-port busy until that port's transaction has finished on the bus.

---
 rtl/i2c_config_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_i2c_config_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_config_arbiter.sv
// i2c_config_arbiter: shares one I2C master between the HDMI transmitter
// config queue (port 0) and the audio codec config queue (port 1).
// Each port hands over one 3-byte write; ports are granted round-robin.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus free; pick an owner once something is pending and m_busy=0
// ISSUE     | one-cycle m_start to the master, acknowledge counter cleared
// WAIT_BUSY | waiting for the master to raise m_busy; abort on timeout
// WAIT_DONE | master working; transaction ends when m_busy falls
module i2c_config_arbiter #(
    parameter int BUSY_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_start,
    input  logic [6:0] req0_address,
    input  logic [7:0] req0_data_0,
    input  logic [7:0] req0_data_1,
    output logic       req0_busy,
    input  logic       req1_start,
    input  logic [6:0] req1_address,
    input  logic [7:0] req1_data_0,
    input  logic [7:0] req1_data_1,
    output logic       req1_busy,
    input  logic       m_busy,
    output logic       m_start,
    output logic [6:0] m_address,
    output logic [7:0] m_data_0,
    output logic [7:0] m_data_1,
    output logic [1:0] grant,
    output logic       err
);

    localparam int CW = $clog2(BUSY_WAIT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    pending_q, pending_d;
    logic          last_served_q, last_served_d;
    logic [1:0]    grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    hold0_addr_q, hold1_addr_q;
    logic [7:0]    hold0_d0_q, hold0_d1_q, hold1_d0_q, hold1_d1_q;
    logic [6:0]    m_address_q;
    logic [7:0]    m_data_0_q, m_data_1_q;

    logic sel;
    logic load;
    logic finish;
    logic timeout;
    logic owner;
    logic accept0;
    logic accept1;

    // The current owner; only meaningful while a grant is held.
    assign owner   = grant_q[1];
    assign accept0 = req0_start & ~req0_busy;
    assign accept1 = req1_start & ~req1_busy;

    assign req0_busy = pending_q[0] | (grant_q[0] & (state_q != IDLE));
    assign req1_busy = pending_q[1] | (grant_q[1] & (state_q != IDLE));
    assign grant     = grant_q;
    assign m_address = m_address_q;
    assign m_data_0  = m_data_0_q;
    assign m_data_1  = m_data_1_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state decision plus the load/finish strobes that steer the datapath.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        finish  = 1'b0;
        timeout = 1'b0;
        case (pending_q)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            default: sel = ~last_served_q;
        endcase
        case (state_q)
            IDLE: begin
                if ((pending_q != 2'b00) && !m_busy) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (m_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_WAIT - 1)) begin
                    timeout = 1'b1;
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!m_busy) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        m_start = (state_q == ISSUE);
        err     = timeout;
    end

    // Next values for the pending flags, round-robin pointer, grant and counter.
    always_comb begin
        pending_d = pending_q;
        if (finish) pending_d[owner] = 1'b0;
        if (accept0) pending_d[0] = 1'b1;
        if (accept1) pending_d[1] = 1'b1;

        last_served_d = finish ? owner : last_served_q;

        grant_d = grant_q;
        if (load)        grant_d = sel ? 2'b10 : 2'b01;
        else if (finish) grant_d = 2'b00;

        // Counter stops at the timeout compare, so it can never wrap.
        cnt_d = cnt_q;
        if (state_q == ISSUE)
            cnt_d = '0;
        else if ((state_q == WAIT_BUSY) && !m_busy && !timeout)
            cnt_d = cnt_q + 1'b1;
    end

    // Datapath registers: request capture, bus payload, arbitration state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q     <= 2'b00;
            last_served_q <= 1'b1;
            grant_q       <= 2'b00;
            cnt_q         <= '0;
            hold0_addr_q  <= '0;
            hold0_d0_q    <= '0;
            hold0_d1_q    <= '0;
            hold1_addr_q  <= '0;
            hold1_d0_q    <= '0;
            hold1_d1_q    <= '0;
            m_address_q   <= '0;
            m_data_0_q    <= '0;
            m_data_1_q    <= '0;
        end else begin
            pending_q     <= pending_d;
            last_served_q <= last_served_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            if (accept0) begin
                hold0_addr_q <= req0_address;
                hold0_d0_q   <= req0_data_0;
                hold0_d1_q   <= req0_data_1;
            end
            if (accept1) begin
                hold1_addr_q <= req1_address;
                hold1_d0_q   <= req1_data_0;
                hold1_d1_q   <= req1_data_1;
            end
            // Payload stays on the bus after completion until the next load.
            if (load) begin
                m_address_q <= sel ? hold1_addr_q : hold0_addr_q;
                m_data_0_q  <= sel ? hold1_d0_q   : hold0_d0_q;
                m_data_1_q  <= sel ? hold1_d1_q   : hold0_d1_q;
            end
        end
    end

endmodule

// File: tb/tb_i2c_config_arbiter.sv
// Testbench for i2c_config_arbiter: directed stimulus, payloads scoreboarded
// per port and checked by a monitor on every m_start; a simple master model
// answers m_start with a programmable busy delay and length.
`timescale 1ns/1ps
module tb_i2c_config_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_start, req1_start;
    logic [6:0] req0_address, req1_address;
    logic [7:0] req0_data_0, req0_data_1, req1_data_0, req1_data_1;
    logic       req0_busy, req1_busy;
    logic       m_busy;
    logic       m_start;
    logic [6:0] m_address;
    logic [7:0] m_data_0, m_data_1;
    logic [1:0] grant;
    logic       err;

    always #5 clk = ~clk;

    i2c_config_arbiter #(.BUSY_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .req0_start(req0_start), .req0_address(req0_address),
        .req0_data_0(req0_data_0), .req0_data_1(req0_data_1), .req0_busy(req0_busy),
        .req1_start(req1_start), .req1_address(req1_address),
        .req1_data_0(req1_data_0), .req1_data_1(req1_data_1), .req1_busy(req1_busy),
        .m_busy(m_busy), .m_start(m_start), .m_address(m_address),
        .m_data_0(m_data_0), .m_data_1(m_data_1), .grant(grant), .err(err)
    );

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d0;
        logic [7:0] d1;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    int   ord_q[$];
    int   total = 0;
    int   bad = 0;
    int   mstart_cnt = 0;
    int   err_cnt = 0;

    logic       mb_model = 1'b0;
    logic       force_busy = 1'b0;
    logic [1:0] no_resp = 2'b00;
    int         resp_delay = 2;
    int         resp_hold = 20;

    assign m_busy = mb_model | force_busy;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Master model: answers each m_start unless that port is muted.
    initial forever begin
        @(negedge clk);
        if (m_start && ((grant & no_resp) == 2'b00)) begin
            repeat (resp_delay) @(negedge clk);
            mb_model = 1'b1;
            repeat (resp_hold) @(negedge clk);
            mb_model = 1'b0;
        end
    end

    // Monitor: pops the expected payload for the granted port on every m_start.
    txn_t got, exp_t;
    int   mon_p;
    initial forever begin
        @(negedge clk);
        #2;
        if (rst) chk("grant_no_overlap", 32'(grant != 2'b11), 32'd1);
        if (m_start) begin
            mstart_cnt++;
            got = {m_address, m_data_0, m_data_1};
            chk("start_grant_onehot", 32'((grant == 2'b01) || (grant == 2'b10)), 32'd1);
            mon_p = grant[1] ? 1 : 0;
            if ((mon_p == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL unexpected_start: port %0d got %h expected none", mon_p, got);
            end else begin
                if (mon_p == 0) exp_t = q0.pop_front();
                else            exp_t = q1.pop_front();
                chk("payload", 32'(got), 32'(exp_t));
            end
            if (ord_q.size() > 0) chk("service_order", 32'(mon_p), 32'(ord_q.pop_front()));
        end
        if (err) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [6:0] a, input logic [7:0] d0,
                         input logic [7:0] d1, input bit push);
        txn_t t;
        t = {a, d0, d1};
        if (p == 0) begin
            req0_start = 1'b1; req0_address = a; req0_data_0 = d0; req0_data_1 = d1;
            if (push) q0.push_back(t);
        end else begin
            req1_start = 1'b1; req1_address = a; req1_data_0 = d0; req1_data_1 = d1;
            if (push) q1.push_back(t);
        end
    endtask

    task automatic send(input int p, input logic [6:0] a, input logic [7:0] d0,
                        input logic [7:0] d1, input bit push);
        drive(p, a, d0, d1, push);
        tick();
        if (p == 0) req0_start = 1'b0;
        else        req1_start = 1'b0;
    endtask

    task automatic wait_free(input int p, input string nm);
        int n = 0;
        while (((p == 0) ? req0_busy : req1_busy) && (n < 400)) begin
            tick();
            n++;
        end
        chk(nm, 32'(n < 400), 32'd1);
    endtask

    int base;
    int n;
    int low;
    bit seen;

    initial begin
        rst = 1'b0;
        req0_start = 0; req0_address = 0; req0_data_0 = 0; req0_data_1 = 0;
        req1_start = 0; req1_address = 0; req1_data_0 = 0; req1_data_1 = 0;
        tick(); tick();
        chk("reset_outputs", 32'({m_start, m_address, m_data_0, m_data_1, grant, err,
                                  req0_busy, req1_busy}), 32'd0);
        rst = 1'b1;
        tick(); tick();

        // Single request with request-to-grant latency and completion timing.
        base = mstart_cnt;
        ord_q.push_back(0);
        send(0, 7'h39, 8'h98, 8'h03, 1);
        chk("t1_busy_after_capture", 32'(req0_busy), 32'd1);
        chk("t1_no_grant_yet", 32'(grant), 32'd0);
        tick();
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_mstart", 32'(m_start), 32'd1);
        chk("t1_addr", 32'(m_address), 32'h39);
        seen = 0; low = 0; n = 0;
        while (req0_busy && (n < 100)) begin
            if (m_busy) seen = 1;
            else if (seen) low++;
            tick();
            n++;
        end
        chk("t1_done_in_time", 32'(n < 100), 32'd1);
        chk("t1_busy_drop_delay", 32'(low), 32'd1);
        chk("t1_grant_cleared", 32'(grant), 32'd0);
        chk("t1_payload_held", 32'({m_address, m_data_0, m_data_1}), 32'({7'h39, 8'h98, 8'h03}));
        chk("t1_start_count", 32'(mstart_cnt - base), 32'd1);
        chk("t1_no_err", 32'(err_cnt), 32'd0);

        rst = 1'b0; tick(); rst = 1'b1; tick();

        // Simultaneous pair from reset: port 0 wins the tie.
        base = mstart_cnt;
        ord_q.push_back(0); ord_q.push_back(1);
        drive(0, 7'h39, 8'h41, 8'h10, 1);
        drive(1, 7'h1A, 8'h0F, 8'h00, 1);
        tick();
        req0_start = 0; req1_start = 0;
        chk("pa_both_busy", 32'({req0_busy, req1_busy}), 32'd3);
        wait_free(0, "pa_port0_done");
        wait_free(1, "pa_port1_done");
        chk("pa_start_count", 32'(mstart_cnt - base), 32'd2);

        // Restart while busy is ignored.
        base = mstart_cnt;
        ord_q.push_back(0);
        send(0, 7'h50, 8'h11, 8'h22, 1);
        send(0, 7'h51, 8'h99, 8'h88, 0);
        n = 0;
        while (!m_busy && (n < 20)) begin tick(); n++; end
        chk("rs_master_busy", 32'(n < 20), 32'd1);
        send(0, 7'h52, 8'h77, 8'h66, 0);
        wait_free(0, "rs_done");
        chk("rs_bus_payload", 32'({m_address, m_data_0, m_data_1}), 32'({7'h50, 8'h11, 8'h22}));
        repeat (5) tick();
        chk("rs_start_count", 32'(mstart_cnt - base), 32'd1);

        // Second simultaneous pair: last served was port 0, so port 1 goes first.
        base = mstart_cnt;
        ord_q.push_back(1); ord_q.push_back(0);
        drive(0, 7'h39, 8'h42, 8'h11, 1);
        drive(1, 7'h1A, 8'h10, 8'h01, 1);
        tick();
        req0_start = 0; req1_start = 0;
        wait_free(0, "pb_port0_done");
        wait_free(1, "pb_port1_done");
        chk("pb_start_count", 32'(mstart_cnt - base), 32'd2);

        // Timeout on port 0 with port 1 queued behind it.
        no_resp = 2'b01; resp_delay = 1; resp_hold = 5;
        base = err_cnt;
        ord_q.push_back(0); ord_q.push_back(1);
        send(0, 7'h22, 8'h33, 8'h44, 1);
        send(1, 7'h23, 8'h34, 8'h45, 1);
        n = 0;
        while (!m_start && (n < 20)) begin tick(); n++; end
        chk("to_start_seen", 32'(n < 20), 32'd1);
        n = 0;
        while (!err && (n < 10)) begin tick(); n++; end
        chk("to_err_delay", 32'(n), 32'd4);
        tick();
        chk("to_busy0_cleared", 32'(req0_busy), 32'd0);
        chk("to_grant_cleared", 32'(grant), 32'd0);
        wait_free(1, "to_port1_done");
        chk("to_err_once", 32'(err_cnt - base), 32'd1);
        no_resp = 2'b00;

        // Asynchronous reset during WAIT_DONE with port 1 pending.
        resp_delay = 2; resp_hold = 20;
        base = mstart_cnt;
        ord_q.push_back(0);
        send(0, 7'h60, 8'h01, 8'h02, 1);
        send(1, 7'h61, 8'h03, 8'h04, 0);
        n = 0;
        while (!m_busy && (n < 20)) begin tick(); n++; end
        tick(); tick();
        chk("ar_req1_pending", 32'(req1_busy), 32'd1);
        chk("ar_grant_before", 32'(grant), 32'd1);
        rst = 1'b0;
        #1;
        chk("ar_outputs_zero", 32'({m_start, m_address, m_data_0, m_data_1, grant, err,
                                    req0_busy, req1_busy}), 32'd0);
        tick();
        rst = 1'b1;
        repeat (40) tick();
        chk("ar_no_restart", 32'(mstart_cnt - base), 32'd1);
        ord_q.push_back(1);
        send(1, 7'h62, 8'h05, 8'h06, 1);
        wait_free(1, "ar_new_req_done");
        chk("ar_new_start", 32'(mstart_cnt - base), 32'd2);

        // Master busy from another agent blocks grants.
        base = mstart_cnt;
        force_busy = 1'b1;
        ord_q.push_back(0);
        send(0, 7'h70, 8'h07, 8'h08, 1);
        repeat (8) tick();
        chk("fb_no_grant", 32'(grant), 32'd0);
        chk("fb_still_pending", 32'(req0_busy), 32'd1);
        force_busy = 1'b0;
        wait_free(0, "fb_done");
        chk("fb_start_count", 32'(mstart_cnt - base), 32'd1);

        // Queue traffic: 31 port-0 writes back to back, 10 port-1 writes interleaved.
        resp_delay = 1; resp_hold = 3;
        base = mstart_cnt;
        fork
            begin
                for (int i = 0; i < 31; i++) begin
                    wait_free(0, "tr_port0_free");
                    send(0, 7'h39, 8'(i * 3), 8'(~i), 1);
                end
                wait_free(0, "tr_port0_last");
            end
            begin
                for (int j = 0; j < 10; j++) begin
                    repeat (5 + (j % 4)) tick();
                    wait_free(1, "tr_port1_free");
                    send(1, 7'h1A, 8'(8'h80 + j), 8'(j * 5), 1);
                end
                wait_free(1, "tr_port1_last");
            end
        join
        repeat (5) tick();
        chk("tr_start_count", 32'(mstart_cnt - base), 32'd41);
        chk("tr_q0_drained", 32'(q0.size()), 32'd0);
        chk("tr_q1_drained", 32'(q1.size()), 32'd0);
        chk("final_err_count", 32'(err_cnt), 32'd1);
        chk("final_order_drained", 32'(ord_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
